// File: rtl/dpr_gen.sv
// Parametrised dual-port RAM: port 1 read-only with write bypass, port 2 read/write.
// Define DPR_CLEAR_EN to build in the post-reset clear sequencer that fills every word with FILL.
module dpr_gen #(
   parameter int            DW   = 8,
   parameter int            AW   = 14,
   parameter int            OREG = 0,
   parameter logic [DW-1:0] FILL = '0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce1,
   input  logic [AW-1:0] a1,
   output logic [DW-1:0] do1,
   input  logic          ce2,
   input  logic          we2,
   input  logic [AW-1:0] a2,
   input  logic [DW-1:0] di2,
   output logic [DW-1:0] do2,
   output logic          busy
);
   localparam int DEPTH = 2**AW;

   logic [DW-1:0] mem [0:DEPTH-1];

   logic          busy_int;
   logic          seq_write;
   logic [AW-1:0] seq_addr;
   logic          p2_write;
   logic          bypass;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] s1_do1_reg;
   logic [DW-1:0] s1_do2_reg;

`ifdef DPR_CLEAR_EN
   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state_reg;
   logic [AW-1:0] cnt_reg;
   logic          busy_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= CLEAR;
         cnt_reg   <= '0;
         busy_reg  <= 1'b1;
      end else begin
         case (state_reg)
            CLEAR: begin
               cnt_reg <= cnt_reg + AW'(1);
               // The last word is written on the same edge that drops busy.
               if (&cnt_reg) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_int  = busy_reg;
   assign seq_write = (state_reg == CLEAR) && !reset;
   assign seq_addr  = cnt_reg;
`else
   assign busy_int  = 1'b0;
   assign seq_write = 1'b0;
   assign seq_addr  = '0;
`endif

   assign busy     = busy_int;
   assign p2_write = ce2 && !we2 && !busy_int;
   assign bypass   = p2_write && (a1 == a2);

   // Single physical write port shared by the sweep and the CPU side.
   always_comb begin
      wr_en   = seq_write || p2_write;
      wr_addr = seq_write ? seq_addr : a2;
      wr_data = seq_write ? FILL : di2;
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_do1_reg <= '0;
         s1_do2_reg <= '0;
      end else begin
         if (ce1 && !busy_int)
            s1_do1_reg <= bypass ? di2 : mem[a1];
         if (ce2 && we2 && !busy_int)
            s1_do2_reg <= mem[a2];
      end
   end

   generate
      if (OREG != 0) begin : g_oreg
         logic [DW-1:0] do1_reg;
         logic [DW-1:0] do2_reg;

         always_ff @(posedge clock) begin
            if (reset) begin
               do1_reg <= '0;
               do2_reg <= '0;
            end else begin
               do1_reg <= s1_do1_reg;
               do2_reg <= s1_do2_reg;
            end
         end

         assign do1 = do1_reg;
         assign do2 = do2_reg;
      end else begin : g_noreg
         assign do1 = s1_do1_reg;
         assign do2 = s1_do2_reg;
      end
   endgenerate
endmodule

// File: tb/tb_dpr_gen.sv
// Bench for dpr_gen: OREG=0 and OREG=1 instances share stimulus; a memory-level model
// predicts both every cycle, with literal checks on the hand-computed test-plan values.
module tb_dpr_gen;
   localparam int            DW   = 8;
   localparam int            AW   = 4;
   localparam int            NW   = 16;
   localparam logic [DW-1:0] FILL = 8'h55;

   logic          clock = 1'b0;
   logic          reset;
   logic          ce1, ce2, we2;
   logic [AW-1:0] a1, a2;
   logic [DW-1:0] di2;
   logic [DW-1:0] do1_0, do2_0, do1_1, do2_1;
   logic          busy_0, busy_1;

   int n_pass  = 0;
   int n_total = 0;
   bit armed   = 1'b0;

   always #5 clock = ~clock;

   dpr_gen #(.DW(DW), .AW(AW), .OREG(0), .FILL(FILL)) u0 (
      .clock(clock), .reset(reset), .ce1(ce1), .a1(a1), .do1(do1_0),
      .ce2(ce2), .we2(we2), .a2(a2), .di2(di2), .do2(do2_0), .busy(busy_0));

   dpr_gen #(.DW(DW), .AW(AW), .OREG(1), .FILL(FILL)) u1 (
      .clock(clock), .reset(reset), .ce1(ce1), .a1(a1), .do1(do1_1),
      .ce2(ce2), .we2(we2), .a2(a2), .di2(di2), .do2(do2_1), .busy(busy_1));

   // Model: word array plus "edges since reset release"; the whole array becomes FILL
   // once the sweep would have finished.
   logic [DW-1:0] m_mem [NW];
   logic [DW-1:0] e1, e2, e1_q, e2_q;
   logic          e_busy;
   int            k = 0;

   initial begin
      for (int i = 0; i < NW; i++) m_mem[i] = 'x;
      e1 = 'x; e2 = 'x; e1_q = 'x; e2_q = 'x; e_busy = 1'bx;
   end

   always @(posedge clock) begin
      logic cur_busy;
      logic wr;
`ifdef DPR_CLEAR_EN
      cur_busy = (k < NW);
`else
      cur_busy = 1'b0;
`endif
      if (reset) begin
         e1 = '0; e2 = '0; e1_q = '0; e2_q = '0;
         k = 0;
      end else begin
         e1_q = e1;
         e2_q = e2;
         wr = ce2 && !we2 && !cur_busy;
         if (!cur_busy) begin
            if (ce1) e1 = (wr && a1 == a2) ? di2 : m_mem[a1];
            if (ce2 && we2) e2 = m_mem[a2];
         end
         if (wr) m_mem[a2] = di2;
         if (k < NW) begin
            k++;
`ifdef DPR_CLEAR_EN
            if (k == NW)
               for (int i = 0; i < NW; i++) m_mem[i] = FILL;
`endif
         end
      end
`ifdef DPR_CLEAR_EN
      e_busy = (k < NW);
`else
      e_busy = 1'b0;
`endif
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clock) begin
      if (armed) begin
         if (!$isunknown(e1))     chk("m_do1_l1", 32'(do1_0), 32'(e1));
         if (!$isunknown(e2))     chk("m_do2_l1", 32'(do2_0), 32'(e2));
         if (!$isunknown(e1_q))   chk("m_do1_l2", 32'(do1_1), 32'(e1_q));
         if (!$isunknown(e2_q))   chk("m_do2_l2", 32'(do2_1), 32'(e2_q));
         if (!$isunknown(e_busy)) chk("m_busy0", 32'(busy_0), 32'(e_busy));
         if (!$isunknown(e_busy)) chk("m_busy1", 32'(busy_1), 32'(e_busy));
      end
   end

   task automatic tick(input logic c1, input logic [AW-1:0] aa1, input logic c2,
                       input logic w2, input logic [AW-1:0] aa2, input logic [DW-1:0] d2);
      ce1 = c1; a1 = aa1; ce2 = c2; we2 = w2; a2 = aa2; di2 = d2;
      @(posedge clock);
      @(negedge clock);
      $display("txn t=%0t rst=%0b ce1=%0b a1=%0d ce2=%0b we2=%0b a2=%0d di2=%02h -> do1=%02h/%02h do2=%02h/%02h busy=%0b",
               $time, reset, c1, aa1, c2, w2, aa2, d2, do1_0, do1_1, do2_0, do2_1, busy_0);
   endtask

   task automatic idle();
      tick(1'b0, '0, 1'b0, 1'b1, '0, '0);
   endtask

   // Counts edges until busy drops, bounded so a stuck sequencer still ends the run.
   task automatic wait_busy_low(inout int n);
      while (busy_0 !== 1'b0 && n < 40) begin
         idle();
         n++;
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      ce1 = 1'b0; ce2 = 1'b0; we2 = 1'b1; a1 = '0; a2 = '0; di2 = '0;
      @(negedge clock);
      idle();
      armed = 1'b1;
      idle();
      chk("rst_do1", 32'(do1_0), 32'h0);
      chk("rst_do2", 32'(do2_1), 32'h0);
      reset = 1'b0;

`ifdef DPR_CLEAR_EN
      chk("busy_rst", 32'(busy_0), 32'h1);
      tick(1'b0, '0, 1'b1, 1'b0, 4'd2, 8'h99);
      n = 1;
      wait_busy_low(n);
      chk("clear_len", 32'(n), 32'd16);
      for (int i = 0; i < NW; i++) begin
         tick(1'b1, AW'(i), 1'b1, 1'b1, AW'(NW - 1 - i), '0);
         chk("fill_do1", 32'(do1_0), 32'h55);
         chk("fill_do2", 32'(do2_0), 32'h55);
      end
      reset = 1'b1;
      idle();
      reset = 1'b0;
      repeat (8) idle();
      reset = 1'b1;
      idle();
      chk("midrst_do1", 32'(do1_0), 32'h0);
      chk("midrst_do2", 32'(do2_0), 32'h0);
      chk("midrst_busy", 32'(busy_0), 32'h1);
      idle();
      reset = 1'b0;
      n = 0;
      wait_busy_low(n);
      chk("reclear_len", 32'(n), 32'd16);
`else
      tick(1'b0, '0, 1'b1, 1'b0, 4'd5, 8'h77);
      chk("busy_zero", 32'(busy_0), 32'h0);
      tick(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, '0);
      chk("first_wr_do1", 32'(do1_0), 32'h77);
      chk("first_wr_do2", 32'(do2_0), 32'h77);
`endif

      // Write then read the same word from both ports.
      tick(1'b0, '0, 1'b1, 1'b0, 4'd3, 8'hA5);
      tick(1'b1, 4'd3, 1'b1, 1'b1, 4'd3, '0);
      chk("rd_do1", 32'(do1_0), 32'hA5);
      chk("rd_do2", 32'(do2_0), 32'hA5);
      chk("oreg_early", 32'(do1_1 === 8'hA5), 32'h0);
      idle();
      chk("oreg_do1", 32'(do1_1), 32'hA5);
      chk("oreg_do2", 32'(do2_1), 32'hA5);
      repeat (3) idle();
      chk("oreg_hold", 32'(do1_1), 32'hA5);

      // Collisions: same address bypasses, different address reads the old word.
      tick(1'b0, '0, 1'b1, 1'b0, 4'd6, 8'h11);
      tick(1'b1, 4'd7, 1'b1, 1'b0, 4'd7, 8'h3C);
      chk("bypass_do1", 32'(do1_0), 32'h3C);
      tick(1'b1, 4'd6, 1'b1, 1'b0, 4'd6, 8'hE2);
      chk("bypass_new", 32'(do1_0), 32'hE2);
      tick(1'b1, 4'd6, 1'b1, 1'b0, 4'd7, 8'h4D);
      chk("nobypass_do1", 32'(do1_0), 32'hE2);
      tick(1'b1, 4'd7, 1'b0, 1'b1, 4'd7, '0);
      chk("wr_seen_p1", 32'(do1_0), 32'h4D);
      chk("do2_hold", 32'(do2_0), 32'hA5);

      // Sweep: fill with a pattern, then read it back with crossed addresses.
      for (int i = 0; i < NW; i++)
         tick(1'b1, AW'(i + 5), 1'b1, 1'b0, AW'(i), 8'((i * 17) ^ 8'h5A));
      for (int i = 0; i < NW; i++)
         tick(1'b1, AW'(i), (i % 3) != 0, 1'b1, AW'(NW - 1 - i), '0);
      tick(1'b0, '0, 1'b1, 1'b1, 4'd2, '0);
      chk("pat_do2", 32'(do2_0), 32'h78);
      repeat (2) idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
